// File: rtl/mem_responder_pkg.sv
// Shared types, widths and the address-error predicate for mem_responder.
// The predicate is only consulted when MEM_RESPONDER_ERR_CHECK_EN is defined.
package mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Misaligned or beyond the last word; widened so 4*depth cannot overflow.
  function automatic logic addrErr(input logic [ADDR_W-1:0] addr,
                                   input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= (34'(depth) << 2));
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// DEPTH x 32 storage: synchronous write, combinational read, never reset.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              iClk,
  input  logic              iWrEn,
  input  logic [AW-1:0]     iAddr,
  input  logic [DATA_W-1:0] iWdata,
  output logic [DATA_W-1:0] oRdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge iClk) begin
    if (iWrEn) mem[iAddr] <= iWdata;
  end

  assign oRdata = mem[iAddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with LATENCY wait states (IDLE/WAIT/RESP).
// Define MEM_RESPONDER_ERR_CHECK_EN to flag misaligned / out-of-range requests.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqWe,
  input  logic [ADDR_W-1:0] iReqAddr,
  input  logic [DATA_W-1:0] iReqWdata,
  output logic              oRspValid,
  input  logic              iRspReady,
  output logic [DATA_W-1:0] oRspRdata,
  output logic              oRspErr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  LAT_M1   = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        waitCnt;
  logic              reqWe;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;

  logic              curWe;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;
  logic              enterResp;
  logic              errNext;
  logic              wrEn;
  logic [DATA_W-1:0] ramRdata;
  logic [DATA_W-1:0] rdataNext;
  logic              unusedAddrBits;

  // With zero latency RESP is entered on the accept edge itself, before the
  // capture registers hold the request, so the live inputs are used there.
  always_comb begin
    curWe    = reqWe;
    curAddr  = reqAddr;
    curWdata = reqWdata;
    if (state == IDLE) begin
      curWe    = iReqWe;
      curAddr  = iReqAddr;
      curWdata = iReqWdata;
    end
  end

  always_comb begin
    enterResp = 1'b0;
    if (state == IDLE && iReqValid && ZERO_LAT) enterResp = 1'b1;
    if (state == WAIT && waitCnt == 4'd0)       enterResp = 1'b1;
  end

`ifdef MEM_RESPONDER_ERR_CHECK_EN
  assign errNext = addrErr(curAddr, DEPTH);
`else
  assign errNext = 1'b0;
`endif

  assign unusedAddrBits = ^{curAddr[ADDR_W-1:AW+2], curAddr[1:0]};

  // Reset gating keeps a zero-latency request from writing while held in reset.
  assign wrEn      = iReset_n && enterResp && curWe && !errNext;
  assign rdataNext = (curWe || errNext) ? '0 : ramRdata;

  mem_responder_ram #(
    .DEPTH (DEPTH)
  ) uRam (
    .iClk   (iClk),
    .iWrEn  (wrEn),
    .iAddr  (curAddr[AW+1:2]),
    .iWdata (curWdata),
    .oRdata (ramRdata)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state     <= IDLE;
      waitCnt   <= '0;
      reqWe     <= 1'b0;
      reqAddr   <= '0;
      reqWdata  <= '0;
      oReqReady <= 1'b1;
      oRspValid <= 1'b0;
      oRspRdata <= '0;
      oRspErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iReqValid) begin
            reqWe     <= iReqWe;
            reqAddr   <= iReqAddr;
            reqWdata  <= iReqWdata;
            oReqReady <= 1'b0;
            if (ZERO_LAT) begin
              state     <= RESP;
              oRspValid <= 1'b1;
              oRspRdata <= rdataNext;
              oRspErr   <= errNext;
            end else begin
              state   <= WAIT;
              waitCnt <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (enterResp) begin
            state     <= RESP;
            oRspValid <= 1'b1;
            oRspRdata <= rdataNext;
            oRspErr   <= errNext;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          if (iRspReady) begin
            state     <= IDLE;
            oReqReady <= 1'b1;
            oRspValid <= 1'b0;
            oRspRdata <= '0;
            oRspErr   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          oReqReady <= 1'b1;
          oRspValid <= 1'b0;
          oRspRdata <= '0;
          oRspErr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance driven from a vector table
// plus hand sequences, and a LATENCY=0 instance for back-to-back timing.
module tb_mem_responder;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iReqValid = 1'b0, iReqWe = 1'b0, iRspReady = 1'b0;
  logic [31:0] iReqAddr = '0, iReqWdata = '0;
  logic        oReqReady, oRspValid, oRspErr;
  logic [31:0] oRspRdata;

  logic        iReqValid0 = 1'b0, iReqWe0 = 1'b0, iRspReady0 = 1'b0;
  logic [31:0] iReqAddr0 = '0, iReqWdata0 = '0;
  logic        oReqReady0, oRspValid0, oRspErr0;
  logic [31:0] oRspRdata0;

  int errors = 0;
  int checks = 0;

  always #5 iClk = ~iClk;

  mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqWe(iReqWe), .iReqAddr(iReqAddr), .iReqWdata(iReqWdata), .oRspValid(oRspValid),
    .iRspReady(iRspReady), .oRspRdata(oRspRdata), .oRspErr(oRspErr)
  );

  mem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .iClk(iClk), .iReset_n(iReset_n), .iReqValid(iReqValid0), .oReqReady(oReqReady0),
    .iReqWe(iReqWe0), .iReqAddr(iReqAddr0), .iReqWdata(iReqWdata0), .oRspValid(oRspValid0),
    .iRspReady(iRspReady0), .oRspRdata(oRspRdata0), .oRspErr(oRspErr0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for oRspValid; n is negedges seen since the accept edge.
  task automatic waitRsp(output int n);
    n = 0;
    while (oRspValid !== 1'b1 && n < 20) begin
      @(negedge iClk);
      n++;
    end
  endtask

  task automatic doTxn(input vec_t v, input string tag);
    int n;
    @(negedge iClk);
    iReqValid = 1'b1; iReqWe = v.we; iReqAddr = v.addr; iReqWdata = v.wdata;
    chk({tag, ".reqReady"}, 32'(oReqReady), 32'd1);
    @(posedge iClk); #1;
    iReqValid = 1'b0; iReqWe = ~v.we; iReqAddr = 32'hFFFF_FFFC; iReqWdata = ~v.wdata;
    waitRsp(n);
    chk({tag, ".latency"}, 32'(n), 32'd3);
    chk({tag, ".rdata"}, oRspRdata, v.expRdata);
    chk({tag, ".err"}, 32'(oRspErr), 32'(v.expErr));
    iRspReady = 1'b1;
    @(posedge iClk); #1;
    iRspReady = 1'b0;
    chk({tag, ".rspDone"}, 32'(oRspValid), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] held;

    vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h14,  32'h0000A5A5, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 32'h14,  32'h0,        32'h0000A5A5, 1'b0};
    vecs[4] = '{1'b1, 32'h0,   32'hCAFE0000, 32'h0,        1'b0};
    vecs[5] = '{1'b0, 32'hFC,  32'h0,        32'hXXXXXXXX, 1'b0};
`ifdef MEM_RESPONDER_ERR_CHECK_EN
    vecs[5] = '{1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
    vecs[6] = '{1'b1, 32'h100, 32'h12345678, 32'h0,        1'b1};
    vecs[7] = '{1'b0, 32'h0,   32'h0,        32'hCAFE0000, 1'b0};
`else
    vecs[5] = '{1'b0, 32'h13,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6] = '{1'b1, 32'h100, 32'h12345678, 32'h0,        1'b0};
    vecs[7] = '{1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0};
`endif
    vecs[8] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};

    repeat (2) @(negedge iClk);
    chk("rst.reqReady", 32'(oReqReady), 32'd1);
    chk("rst.rspValid", 32'(oRspValid), 32'd0);
    chk("rst.rdata", oRspRdata, 32'h0);
    chk("rst.err", 32'(oRspErr), 32'd0);
    iReset_n = 1'b1;

    for (int i = 0; i < 9; i++) doTxn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5 cycles while a second request waits.
    @(negedge iClk);
    iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 32'h10;
    @(posedge iClk); #1;
    iReqAddr = 32'h14;
    waitRsp(n);
    chk("bp.latency", 32'(n), 32'd3);
    held = oRspRdata;
    chk("bp.rdata", held, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      chk($sformatf("bp.valid%0d", c), 32'(oRspValid), 32'd1);
      chk($sformatf("bp.hold%0d", c), oRspRdata, 32'hDEADBEEF);
      chk($sformatf("bp.noAccept%0d", c), 32'(oReqReady), 32'd0);
    end
    iRspReady = 1'b1;
    @(posedge iClk); #1;
    iRspReady = 1'b0;
    chk("bp.readyAfter", 32'(oReqReady), 32'd1);
    chk("bp.validAfter", 32'(oRspValid), 32'd0);
    @(posedge iClk); #1;
    iReqValid = 1'b0;
    chk("bp.accepted", 32'(oReqReady), 32'd0);
    waitRsp(n);
    chk("bp2.latency", 32'(n), 32'd3);
    chk("bp2.rdata", oRspRdata, 32'h0000A5A5);
    iRspReady = 1'b1;
    @(posedge iClk); #1;
    iRspReady = 1'b0;

    // Asynchronous reset while a response is pending.
    @(negedge iClk);
    iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 32'h10;
    @(posedge iClk); #1;
    iReqValid = 1'b0;
    waitRsp(n);
    chk("arst.pre", 32'(oRspValid), 32'd1);
    #2 iReset_n = 1'b0;
    #1;
    chk("arst.reqReady", 32'(oReqReady), 32'd1);
    chk("arst.rspValid", 32'(oRspValid), 32'd0);
    chk("arst.rdata", oRspRdata, 32'h0);
    chk("arst.err", 32'(oRspErr), 32'd0);
    @(negedge iClk);
    iReset_n = 1'b1;

    // Reset during WAIT drops the store to word 8.
    doTxn('{1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0}, "w8init");
    @(negedge iClk);
    iReqValid = 1'b1; iReqWe = 1'b1; iReqAddr = 32'h20; iReqWdata = 32'h22222222;
    @(posedge iClk); #1;
    iReqValid = 1'b0;
    @(negedge iClk);
    iReset_n = 1'b0;
    @(negedge iClk);
    iReset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      if (oRspValid === 1'b1) seen++;
    end
    chk("wrst.noResp", 32'(seen), 32'd0);
    doTxn('{1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0}, "wrst.load");

    // LATENCY=0 instance: store, then back-to-back loads with ready held high.
    @(negedge iClk);
    iReqValid0 = 1'b1; iReqWe0 = 1'b1; iReqAddr0 = 32'h8; iReqWdata0 = 32'h55AA55AA;
    iRspReady0 = 1'b1;
    @(posedge iClk); #1;
    iReqValid0 = 1'b0;
    @(negedge iClk);
    chk("l0.storeValid", 32'(oRspValid0), 32'd1);
    chk("l0.storeRdata", oRspRdata0, 32'h0);
    @(posedge iClk); #1;
    iReqValid0 = 1'b1; iReqWe0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge iClk);
      chk($sformatf("l0.ready%0d", c), 32'(oReqReady0), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("l0.valid%0d", c), 32'(oRspValid0), (c % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("l0.rdata%0d", c), oRspRdata0, (c % 2 == 1) ? 32'h55AA55AA : 32'h0);
    end
    iReqValid0 = 1'b0;
    iRspReady0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit storage words (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, wait-state cycles between request accept and response (0..15).
REQ-003 SHALL have port iClk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port iReset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iReqValid  input  1  initiator presents a request.
REQ-006 SHALL have port oReqReady  output  1  responder can accept a request.
REQ-007 SHALL have port iReqWe  input  1  1 = store, 0 = load.
REQ-008 SHALL have port iReqAddr  input  32  byte address.
REQ-009 SHALL have port iReqWdata  input  32  store data.
REQ-010 SHALL have port oRspValid  output  1  response available.
REQ-011 SHALL have port iRspReady  input  1  initiator consumes the response.
REQ-012 SHALL have port oRspRdata  output  32  load data; 0 for stores.
REQ-013 SHALL have port oRspErr  output  1  error flag for the response.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive oReqReady=1 only in IDLE; request accepted on the cycle iReqValid & oReqReady.
REQ-016 SHALL capture iReqWe, iReqAddr and iReqWdata at accept; later input changes SHALL have no effect.
REQ-017 SHALL go IDLE->WAIT on accept when LATENCY>0, with a wait counter loaded to LATENCY-1; IDLE->RESP directly when LATENCY=0.
REQ-018 SHALL decrement the counter in WAIT and go WAIT->RESP when it reaches 0; response appears LATENCY+1 cycles after the accept edge.
REQ-019 SHALL commit a store to storage and latch load data on the edge entering RESP, never earlier.
REQ-020 SHALL index storage by iReqAddr[log2(DEPTH)+1:2].
REQ-021 SHALL hold oRspValid=1 with stable oRspRdata/oRspErr in RESP until iRspReady=1; then go RESP->IDLE.
REQ-022 SHALL ignore iReqValid in WAIT and RESP: one outstanding request, no accept in the response-handshake cycle.
REQ-023 SHALL drive oRspRdata=0 and oRspErr=0 in IDLE and WAIT.

Reset
REQ-024 SHALL on iReset_n=0 force IDLE, counter=0, oReqReady=1, oRspValid=0, oRspRdata=0, oRspErr=0, independent of iClk.
REQ-025 SHALL on reset in WAIT abandon the pending request: uncommitted store never written, no response issued.
REQ-026 SHALL not clear storage contents on reset.

Configuration
REQ-027 SHALL, with MEM_RESPONDER_ERR_CHECK_EN defined, flag the request in error when iReqAddr[1:0]!=0 or iReqAddr>=4*DEPTH: no storage write, oRspRdata=0, oRspErr=1 in RESP, same timing as a good request.
REQ-028 SHALL, without MEM_RESPONDER_ERR_CHECK_EN, tie oRspErr to 0, ignore iReqAddr[1:0], and wrap addresses modulo DEPTH words.

Structure
REQ-029 SHALL place the state enum typedef, DATA_W=32, ADDR_W=32 and the error-check predicate in shared package mem_responder_pkg.
REQ-030 SHALL implement storage in sub-module mem_responder_ram: synchronous write, combinational read, DEPTH x 32.

Verification (DEPTH=64, LATENCY=2 unless stated)
REQ-031 SHALL check reset: iReset_n low mid-cycle -> oReqReady=1, oRspValid=0, oRspRdata=0, oRspErr=0 immediately.
REQ-032 SHALL check store then load: store 0xDEADBEEF to 0x10 accepted at cycle 0 -> oRspValid=1 at cycle 3, rdata 0, err 0; load 0x10 -> rdata 0xDEADBEEF.
REQ-033 SHALL check backpressure: iRspReady low 5 cycles in RESP -> oRspValid and oRspRdata stable; iReqValid=1 with oReqReady=0 not accepted; accept resumes the cycle after the handshake.
REQ-034 SHALL check errors: with macro, load 0x13 -> err 1, rdata 0; store 0x100 -> err 1, word 0 unchanged. Without macro, store 0x12345678 to 0x100 -> word 0 reads 0x12345678.
REQ-035 SHALL check reset mid-WAIT: word 8 holds 0x11111111, store 0x22222222 to 0x20, reset at cycle 1 -> no response; load 0x20 -> 0x11111111.
REQ-036 SHALL check LATENCY=0: request accepted at cycle 0 -> oRspValid=1 at cycle 1, back-to-back accepts every 2 cycles with iRspReady=1.
